// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet types and TX arbiter FSM encoding
//
// Purpose: common typedefs for the Ethernet transmit path.
//   mac_addr_t          48-bit MAC address
//   eth_type_t          16-bit EtherType
//   eth_header_t        packed {dest_mac, src_mac, eth_type}
//   eth_tx_arb_state_t  IDLE / HEADER / PAYLOAD states of eth_tx_arbiter
package eth_pkg;

    localparam int MAC_WIDTH  = 48;
    localparam int TYPE_WIDTH = 16;

    typedef logic [MAC_WIDTH-1:0]  mac_addr_t;
    typedef logic [TYPE_WIDTH-1:0] eth_type_t;

    typedef struct packed {
        mac_addr_t dest_mac;
        mac_addr_t src_mac;
        eth_type_t eth_type;
    } eth_header_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } eth_tx_arb_state_t;

endpackage

// File: rtl/eth_if.sv
// rtl/eth_if.sv - Ethernet header and AXI-Stream payload interfaces
//
// Purpose: point-to-point bundles between the TX arbiter and the framer.
//   ETH_HEADER_IF  valid/ready handshake carrying dest_mac, src_mac, eth_type
//   AXIS_IF        tdata/tkeep/tvalid/tready/tlast/tuser stream
//                  (no tid/tdest: those widths are zero in this path)
// Modports: Transmitter drives the payload and valid, Receiver drives ready.
interface ETH_HEADER_IF;
    import eth_pkg::*;

    logic      valid;
    logic      ready;
    mac_addr_t dest_mac;
    mac_addr_t src_mac;
    eth_type_t eth_type;

    modport Transmitter (output valid, output dest_mac, output src_mac,
                         output eth_type, input ready);
    modport Receiver    (input valid, input dest_mac, input src_mac,
                         input eth_type, output ready);
endinterface

interface AXIS_IF #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int TUSER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0]  tdata;
    logic [KEEP_WIDTH-1:0]  tkeep;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;

    modport Transmitter (output tdata, output tkeep, output tvalid,
                         output tlast, output tuser, input tready);
    modport Receiver    (input tdata, input tkeep, input tvalid,
                         input tlast, input tuser, output tready);
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin request selector
//
// Purpose: picks the first set request bit searching upward from
// last_grant_i+1, wrapping modulo NUM_PORTS.
// Ports:
//   req_i          in   NUM_PORTS   request vector
//   last_grant_i   in   IDX_WIDTH   index served most recently
//   grant_index_o  out  IDX_WIDTH   selected index (0 when none found)
//   grant_found_o  out  1           at least one request is set
module rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_WIDTH-1:0] last_grant_i,
    output logic [IDX_WIDTH-1:0] grant_index_o,
    output logic                 grant_found_o
);

    // One spare bit so last_grant + offset never overflows before the wrap.
    logic [IDX_WIDTH:0] cand;

    always_comb begin
        grant_index_o = '0;
        grant_found_o = 1'b0;
        cand          = '0;
        // Offset NUM_PORTS lands back on last_grant itself, so a lone
        // requester that was just served can still win.
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand = {1'b0, last_grant_i} + (IDX_WIDTH+1)'(off);
            if (cand >= (IDX_WIDTH+1)'(NUM_PORTS)) begin
                cand = cand - (IDX_WIDTH+1)'(NUM_PORTS);
            end
            if (!grant_found_o && req_i[cand[IDX_WIDTH-1:0]]) begin
                grant_found_o = 1'b1;
                grant_index_o = cand[IDX_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - round-robin frame arbiter in front of the Ethernet TX framer
//
// Purpose: grants one of NUM_PORTS requesters at a time and forwards its
// header, then its whole payload frame, so frames never interleave.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   s_hdr_valid/ready                per-port header handshake
//   s_hdr_dest_mac/src_mac/type      per-port header fields (packed by port)
//   s_axis_tdata/tkeep/tvalid/tlast/tuser, s_axis_tready  per-port payload
//   eth_header_out_if                header to the framer
//   eth_payload_out_if               payload to the framer
//   grant_valid, grant_index         frame in progress and its owner
//   frame_count                      completed frames, wraps
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter  int NUM_PORTS   = 4,
    parameter  int DATA_WIDTH  = 8,
    parameter  int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter  int COUNT_WIDTH = 16,
    localparam int IDX_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             reset_n,

    input  logic [NUM_PORTS-1:0]             s_hdr_valid,
    output logic [NUM_PORTS-1:0]             s_hdr_ready,
    input  logic [NUM_PORTS*MAC_WIDTH-1:0]   s_hdr_dest_mac,
    input  logic [NUM_PORTS*MAC_WIDTH-1:0]   s_hdr_src_mac,
    input  logic [NUM_PORTS*TYPE_WIDTH-1:0]  s_hdr_type,

    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
    output logic [NUM_PORTS-1:0]             s_axis_tready,
    input  logic [NUM_PORTS-1:0]             s_axis_tlast,
    input  logic [NUM_PORTS-1:0]             s_axis_tuser,

    ETH_HEADER_IF.Transmitter                eth_header_out_if,
    AXIS_IF.Transmitter                      eth_payload_out_if,

    output logic                             grant_valid,
    output logic [IDX_WIDTH-1:0]             grant_index,
    output logic [COUNT_WIDTH-1:0]           frame_count
);

    eth_tx_arb_state_t      state_q, state_d;
    logic [IDX_WIDTH-1:0]   grant_index_q, grant_index_d;
    logic [IDX_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic                   grant_valid_q, grant_valid_d;
    logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;

    logic [IDX_WIDTH-1:0]   arb_index;
    logic                   arb_found;

    // Per-port views of the packed inputs, indexed by grant.
    eth_header_t            hdr_a   [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  tdata_a [NUM_PORTS];
    logic [KEEP_WIDTH-1:0]  tkeep_a [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign hdr_a[p] = '{
            dest_mac: s_hdr_dest_mac[p*MAC_WIDTH +: MAC_WIDTH],
            src_mac:  s_hdr_src_mac[p*MAC_WIDTH +: MAC_WIDTH],
            eth_type: s_hdr_type[p*TYPE_WIDTH +: TYPE_WIDTH]
        };
        assign tdata_a[p] = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        assign tkeep_a[p] = s_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
    end

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .req_i         (s_hdr_valid),
        .last_grant_i  (last_grant_q),
        .grant_index_o (arb_index),
        .grant_found_o (arb_found)
    );

    logic hdr_fire;
    logic last_fire;

    assign hdr_fire  = (state_q == ST_HEADER) && s_hdr_valid[grant_index_q]
                       && eth_header_out_if.ready;
    assign last_fire = (state_q == ST_PAYLOAD) && s_axis_tvalid[grant_index_q]
                       && eth_payload_out_if.tready && s_axis_tlast[grant_index_q];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant bookkeeping and frame counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_index_q <= '0;
            // Port 0 is the first candidate after reset.
            last_grant_q  <= IDX_WIDTH'(NUM_PORTS - 1);
            grant_valid_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            grant_index_q <= grant_index_d;
            last_grant_q  <= last_grant_d;
            grant_valid_q <= grant_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        grant_index_d = grant_index_q;
        last_grant_d  = last_grant_q;
        grant_valid_d = grant_valid_q;
        frame_count_d = frame_count_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d       = ST_HEADER;
                    grant_index_d = arb_index;
                    grant_valid_d = 1'b1;
                end
            end
            ST_HEADER: begin
                // Grant is held even if the requester drops header valid.
                if (hdr_fire) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (last_fire) begin
                    state_d       = ST_IDLE;
                    last_grant_d  = grant_index_q;
                    grant_valid_d = 1'b0;
                    frame_count_d = frame_count_q + COUNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output muxes: zero-latency pass-through of the granted port only.
    eth_header_t            hdr_sel;
    logic                   hdr_valid;
    logic [DATA_WIDTH-1:0]  pl_tdata;
    logic [KEEP_WIDTH-1:0]  pl_tkeep;
    logic                   pl_tvalid;
    logic                   pl_tlast;
    logic                   pl_tuser;

    always_comb begin
        s_hdr_ready   = '0;
        s_axis_tready = '0;
        hdr_sel       = '0;
        hdr_valid     = 1'b0;
        pl_tdata      = '0;
        pl_tkeep      = '0;
        pl_tvalid     = 1'b0;
        pl_tlast      = 1'b0;
        pl_tuser      = 1'b0;
        case (state_q)
            ST_HEADER: begin
                hdr_sel                    = hdr_a[grant_index_q];
                hdr_valid                  = s_hdr_valid[grant_index_q];
                s_hdr_ready[grant_index_q] = eth_header_out_if.ready;
            end
            ST_PAYLOAD: begin
                pl_tdata                     = tdata_a[grant_index_q];
                pl_tkeep                     = tkeep_a[grant_index_q];
                pl_tvalid                    = s_axis_tvalid[grant_index_q];
                pl_tlast                     = s_axis_tlast[grant_index_q];
                pl_tuser                     = s_axis_tuser[grant_index_q];
                s_axis_tready[grant_index_q] = eth_payload_out_if.tready;
            end
            default: begin
            end
        endcase
    end

    assign eth_header_out_if.valid    = hdr_valid;
    assign eth_header_out_if.dest_mac = hdr_sel.dest_mac;
    assign eth_header_out_if.src_mac  = hdr_sel.src_mac;
    assign eth_header_out_if.eth_type = hdr_sel.eth_type;

    assign eth_payload_out_if.tdata  = pl_tdata;
    assign eth_payload_out_if.tkeep  = pl_tkeep;
    assign eth_payload_out_if.tvalid = pl_tvalid;
    assign eth_payload_out_if.tlast  = pl_tlast;
    assign eth_payload_out_if.tuser  = pl_tuser;

    assign grant_valid = grant_valid_q;
    assign grant_index = grant_index_q;
    assign frame_count = frame_count_q;

endmodule
